// File: rtl/handshake_skid_slice.sv
// Two-entry valid/ready register slice: every output, including s_ready, comes straight from a flop,
// so ready never ripples combinationally from consumer to producer.
module handshake_skid_slice #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            count
);

  // state | meaning
  // EMPTY | no word held, m_valid=0, s_ready=1
  // BUSY  | output register holds one word
  // FULL  | output register plus skid register hold words, s_ready=0
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] skid;
  logic                  s_fire;
  logic                  m_fire;

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      m_data  <= '0;
      skid    <= '0;
      s_ready <= 1'b1;
      count   <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (s_fire) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            count   <= 2'd1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (s_fire && m_fire) begin
            m_data <= s_data;
          end else if (s_fire) begin
            // consumer stalled: park the new word so m_data stays put
            skid    <= s_data;
            s_ready <= 1'b0;
            count   <= 2'd2;
            state   <= FULL;
          end else if (m_fire) begin
            m_valid <= 1'b0;
            count   <= 2'd0;
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (m_fire) begin
            m_data  <= skid;
            s_ready <= 1'b1;
            count   <= 2'd1;
            state   <= BUSY;
          end
        end
        default: begin
          state   <= EMPTY;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
          count   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_skid_slice.sv
// Bench for handshake_skid_slice: directed handshake scenarios plus a randomised run,
// all checked against a queue-based scoreboard of words accepted upstream.
module tb_handshake_skid_slice;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  handshake_skid_slice #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: at the falling edge inputs and outputs are settled, so the
  // handshakes that will fire at the next rising edge are known.
  always @(negedge clk) begin
    int sz;
    if (!rst_n) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      sz = sb_q.size();
      chk("sb_count", {30'd0, count}, sz[31:0]);
      chk("sb_m_valid", {31'd0, m_valid}, {31'd0, sz != 0});
      chk("sb_s_ready", {31'd0, s_ready}, {31'd0, sz < 2});
      if (prev_stall) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (sz == 0) chk("pop_empty", {31'd0, m_valid}, 32'd0);
        else         chk("sb_order", m_data, sb_q.pop_front());
      end
      if (s_valid && s_ready) sb_q.push_back(s_data);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    // reset held
    repeat (3) cyc();
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_count", {30'd0, count}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // single word pass-through
    s_valid = 1'b1; s_data = 32'd55; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0;
    chk("one_valid", {31'd0, m_valid}, 32'd1);
    chk("one_data", m_data, 32'd55);
    chk("one_count", {30'd0, count}, 32'd1);
    cyc();
    chk("one_gone", {31'd0, m_valid}, 32'd0);
    chk("one_count0", {30'd0, count}, 32'd0);

    // back-to-back stream
    s_valid = 1'b1; s_data = 32'd55;
    cyc();
    s_data = 32'd66;
    chk("str_d0", m_data, 32'd55);
    chk("str_rdy0", {31'd0, s_ready}, 32'd1);
    cyc();
    s_data = 32'd77;
    chk("str_d1", m_data, 32'd66);
    chk("str_cnt1", {30'd0, count}, 32'd1);
    cyc();
    s_valid = 1'b0;
    chk("str_d2", m_data, 32'd77);
    chk("str_rdy2", {31'd0, s_ready}, 32'd1);
    cyc();
    chk("str_empty", {30'd0, count}, 32'd0);

    // fill while stalled, then drain in order
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'd55;
    cyc();
    s_data = 32'd66;
    chk("fill_cnt1", {30'd0, count}, 32'd1);
    cyc();
    s_data = 32'd77;
    chk("fill_cnt2", {30'd0, count}, 32'd2);
    chk("fill_rdy", {31'd0, s_ready}, 32'd0);
    chk("fill_hold", m_data, 32'd55);
    cyc();
    chk("full_cnt", {30'd0, count}, 32'd2);
    chk("full_hold", m_data, 32'd55);
    m_ready = 1'b1;
    cyc();
    chk("drain_d1", m_data, 32'd66);
    chk("drain_rdy", {31'd0, s_ready}, 32'd1);
    cyc();
    s_valid = 1'b0;
    chk("drain_d2", m_data, 32'd77);
    chk("drain_cnt", {30'd0, count}, 32'd1);
    cyc();
    chk("drain_empty", {31'd0, m_valid}, 32'd0);

    // asynchronous reset while full
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'd55;
    cyc();
    s_data = 32'd66;
    cyc();
    s_valid = 1'b0;
    chk("pre_rst_cnt", {30'd0, count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_count", {30'd0, count}, 32'd0);
    chk("arst_ready", {31'd0, s_ready}, 32'd1);
    cyc();
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 32'd88; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0;
    chk("post_rst_d", m_data, 32'd88);
    chk("post_rst_v", {31'd0, m_valid}, 32'd1);
    cyc();
    chk("post_rst_e", {31'd0, m_valid}, 32'd0);

    // randomised traffic
    for (int i = 0; i < 10000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      s_data  = $urandom;
      cyc();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (4) cyc();
    chk("final_count", {30'd0, count}, 32'd0);
    chk("final_valid", {31'd0, m_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
